// File: rtl/tl_sram_responder.sv
// TL-UL single-beat responder terminating Get/PutFull/PutPartial/Hint on a 32-bit word SRAM.
// Latency: an A fire in cycle N gives a registered D response in cycle N+1.
// Backpressure: one response slot, a_ready = !d_valid | d_ready; D bits hold while stalled.
// Optional: define TL_RESP_DENIED_EN to add the auto_in_d_bits_denied output.
module tl_sram_responder #(
    parameter logic [27:0] BASE        = 28'h0000000,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned SOURCE_BITS = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   auto_in_a_ready,
    input  logic                   auto_in_a_valid,
    input  logic [2:0]             auto_in_a_bits_opcode,
    input  logic [2:0]             auto_in_a_bits_param,
    input  logic [1:0]             auto_in_a_bits_size,
    input  logic [SOURCE_BITS-1:0] auto_in_a_bits_source,
    input  logic [27:0]            auto_in_a_bits_address,
    input  logic [3:0]             auto_in_a_bits_mask,
    input  logic [31:0]            auto_in_a_bits_data,
    input  logic                   auto_in_a_bits_corrupt,
    input  logic                   auto_in_d_ready,
    output logic                   auto_in_d_valid,
    output logic [2:0]             auto_in_d_bits_opcode,
    output logic [1:0]             auto_in_d_bits_size,
    output logic [SOURCE_BITS-1:0] auto_in_d_bits_source,
`ifdef TL_RESP_DENIED_EN
    output logic                   auto_in_d_bits_denied,
`endif
    output logic [31:0]            auto_in_d_bits_data
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_HINT        = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    logic [31:0] sram [DEPTH];

    logic                   d_valid_q,  d_valid_d;
    logic [2:0]             d_opcode_q, d_opcode_d;
    logic [1:0]             d_size_q,   d_size_d;
    logic [SOURCE_BITS-1:0] d_source_q, d_source_d;
    logic [31:0]            d_data_q,   d_data_d;
    logic                   d_denied_q, d_denied_d;

    logic                  a_fire;
    logic                  hit;
    logic                  is_put;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           rd_word;

    // Response slot frees when it drains, so a new request can flow in the same cycle.
    assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;

    // Window decode: upper address bits select the window, size 3 is never a hit.
    assign hit      = (auto_in_a_bits_address[27:TAG_LSB] == BASE[27:TAG_LSB])
                   && (auto_in_a_bits_size != 2'd3);
    assign word_idx = auto_in_a_bits_address[TAG_LSB-1:2];
    assign rd_word  = sram[word_idx];
    assign is_put   = (auto_in_a_bits_opcode == A_PUT_FULL)
                   || (auto_in_a_bits_opcode == A_PUT_PARTIAL);
    // Corrupt Puts still get acked but never touch the array; no writes while in reset.
    assign wr_en    = a_fire && !reset && is_put && hit && !auto_in_a_bits_corrupt;

    // Byte-lane write committed at the fire edge, so a Get next cycle sees it; array not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (auto_in_a_bits_mask[i]) begin
                    sram[word_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
                end
            end
        end
    end

    // Next response: load on fire, clear valid on drain, otherwise hold every bit.
    always_comb begin
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_denied_d = d_denied_q;
        if (a_fire) begin
            d_valid_d  = 1'b1;
            d_size_d   = auto_in_a_bits_size;
            d_source_d = auto_in_a_bits_source;
            d_data_d   = '0;
            d_denied_d = !hit;
            case (auto_in_a_bits_opcode)
                A_PUT_FULL, A_PUT_PARTIAL: begin
                    d_opcode_d = D_ACK;
                end
                A_GET: begin
                    d_opcode_d = D_ACK_DATA;
                    d_data_d   = hit ? rd_word : 32'd0;
                end
                A_HINT: begin
                    d_opcode_d = D_HINT_ACK;
                end
                default: begin
                    // Atomics and reserved opcodes: empty data response, flagged as an error.
                    d_opcode_d = D_ACK_DATA;
                    d_denied_d = 1'b1;
                end
            endcase
        end else if (auto_in_d_ready) begin
            d_valid_d = 1'b0;
        end
    end

    // D-channel register; reset drops any pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_denied_q <= 1'b0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_denied_q <= d_denied_d;
        end
    end

    assign auto_in_d_valid       = d_valid_q;
    assign auto_in_d_bits_opcode = d_opcode_q;
    assign auto_in_d_bits_size   = d_size_q;
    assign auto_in_d_bits_source = d_source_q;
    assign auto_in_d_bits_data   = d_data_q;

`ifdef TL_RESP_DENIED_EN
    assign auto_in_d_bits_denied = d_denied_q;
`else
    logic unused_denied;
    assign unused_denied = d_denied_q;
`endif

    // param carries no meaning here and byte offset is implied by mask/size.
    logic unused_a;
    assign unused_a = ^{auto_in_a_bits_param, auto_in_a_bits_address[1:0]};

endmodule
